// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and bit-mixing functions used by the schedule and round stages.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int N_LOAD  = 16;
    localparam int N_ROUND = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DONE
    } state_t;

    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sig0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Round-stage helpers kept here so both stages share one definition.
    function automatic word_t bigSig0(input word_t x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic word_t bigSig1(input word_t x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    localparam word_t K [0:N_ROUND-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_msg_schedule_k_rom.sv
// Round-constant lookup K[round]; only compiled when SHA256_K_ROM_EN is defined.
`ifdef SHA256_K_ROM_EN
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]        round_i,
    output logic [WORD_W-1:0] k_o
);

    assign k_o = K[round_i];

endmodule
`endif

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] with round index.
// Optional feature macro: SHA256_K_ROM_EN (adds K[ROUND] on K_OUT, otherwise K_OUT is 0).
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WORD_W-1:0] IN_WORD,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WORD_W-1:0] W_OUT,
    output logic [WORD_W-1:0] K_OUT,
    output logic [5:0]        ROUND,
    output logic              BLOCK_DONE
);

    state_t      state_q, state_d;
    word_t       win_q [N_LOAD];
    word_t       win_d [N_LOAD];
    logic [3:0]  loadCnt_q, loadCnt_d;
    logic [5:0]  round_q, round_d;
    word_t       nw;

    // win always holds W[t..t+15]; every step shifts down and appends one word at win[15].
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        loadCnt_d = loadCnt_q;
        round_d   = round_q;
        nw        = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

        unique case (state_q)
            LOAD: begin
                if (IN_VALID) begin
                    for (int i = 0; i < N_LOAD - 1; i++) win_d[i] = win_q[i+1];
                    win_d[N_LOAD-1] = IN_WORD;
                    loadCnt_d       = loadCnt_q + 4'd1;
                    if (loadCnt_q == 4'(N_LOAD - 1)) state_d = RUN;
                end
            end
            RUN: begin
                if (OUT_READY) begin
                    for (int i = 0; i < N_LOAD - 1; i++) win_d[i] = win_q[i+1];
                    win_d[N_LOAD-1] = nw;
                    round_d         = round_q + 6'd1;
                    if (round_q == 6'(N_ROUND - 1)) state_d = DONE;
                end
            end
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= LOAD;
            loadCnt_q <= '0;
            round_q   <= '0;
            for (int i = 0; i < N_LOAD; i++) win_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            loadCnt_q <= loadCnt_d;
            round_q   <= round_d;
            win_q     <= win_d;
        end
    end

    assign IN_READY   = (state_q == LOAD) && !RESET;
    assign OUT_VALID  = (state_q == RUN);
    assign BLOCK_DONE = (state_q == DONE);
    assign W_OUT      = win_q[0];
    assign ROUND      = round_q;

`ifdef SHA256_K_ROM_EN
    word_t kRom;

    sha256_k_rom uKRom (
        .round_i (round_q),
        .k_o     (kRom)
    );

    // Gated so K_OUT reads 0 outside RUN, matching its reset value.
    assign K_OUT = OUT_VALID ? kRom : '0;
`else
    assign K_OUT = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: directed blocks, scoreboard of expected W/ROUND.
module tb_sha256_msg_schedule;

    typedef logic [31:0] w32_t;
    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  r;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_WORD;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] W_OUT;
    logic [31:0] K_OUT;
    logic [5:0]  ROUND;
    logic        BLOCK_DONE;

    sha256_msg_schedule dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_WORD    (IN_WORD),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .W_OUT      (W_OUT),
        .K_OUT      (K_OUT),
        .ROUND      (ROUND),
        .BLOCK_DONE (BLOCK_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t  sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    int    doneCount  = 0;
    int    firstAccept = 0;
    w32_t  obsW [64];
    bit    prevStall  = 0;
    w32_t  prevW;
    logic [5:0] prevR;

    always @(posedge CLK) cyc++;

    function automatic w32_t rotr(input w32_t x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic w32_t ssig0(input w32_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ {3'b000, x[31:3]};
    endfunction

    function automatic w32_t ssig1(input w32_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ {10'b0, x[31:10]};
    endfunction

    task automatic checkOutput(input string tag, input w32_t obs, input w32_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected stream is pushed before the block is offered so the monitor can pop it.
    task automatic applyStimulus(input w32_t m [16], input bit holdValid);
        w32_t w [64];
        exp_t e;
        bit   rdy;
        int   guard;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++)
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.w = w[t];
            e.r = 6'(t);
            sb.push_back(e);
        end
        for (int n = 0; n < 16; n++) begin
            IN_VALID = 1'b1;
            IN_WORD  = m[n];
            rdy      = 1'b0;
            guard    = 0;
            while (!rdy && guard < 400) begin
                @(negedge CLK);
                rdy = IN_READY;
                @(posedge CLK);
                #1;
                guard++;
            end
            checkOutput($sformatf("load_accept[%0d]", n), 32'(rdy), 32'd1);
            if (n == 0) firstAccept = cyc;
        end
        IN_VALID = holdValid;
    endtask

    task automatic waitDone(input bit randReady, output int doneAt);
        int guard = 0;
        bit seen  = 1'b0;
        doneAt = 0;
        while (!seen && guard < 2000) begin
            @(negedge CLK);
            if (BLOCK_DONE) begin
                seen   = 1'b1;
                doneAt = cyc;
            end else begin
                @(posedge CLK);
                #1;
                if (randReady) OUT_READY = 1'($urandom_range(0, 1));
                guard++;
            end
        end
        checkOutput("block_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            @(posedge CLK);
            #1;
        end
        OUT_READY = 1'b1;
    endtask

    // Monitor: scoreboard pop on each output transfer plus protocol checks.
    always @(negedge CLK) begin
        exp_t e;
        if (BLOCK_DONE) begin
            doneCount++;
            checkOutput("done_out_valid", 32'(OUT_VALID), 32'd0);
            checkOutput("done_in_ready", 32'(IN_READY), 32'd0);
        end
        if (OUT_VALID) checkOutput("run_in_ready", 32'(IN_READY), 32'd0);
        if (prevStall && OUT_VALID && !RESET) begin
            checkOutput("hold_W", W_OUT, prevW);
            checkOutput("hold_ROUND", 32'(ROUND), 32'(prevR));
        end
        if (!RESET && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL sb_underflow observed W=0x%08h ROUND=%0d expected no output", W_OUT, ROUND);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("W[%0d]", e.r), W_OUT, e.w);
                checkOutput($sformatf("ROUND[%0d]", e.r), 32'(ROUND), 32'(e.r));
`ifdef SHA256_K_ROM_EN
                if (e.r == 6'd0)  checkOutput("K[0]", K_OUT, 32'h428a2f98);
                if (e.r == 6'd63) checkOutput("K[63]", K_OUT, 32'hc67178f2);
`else
                checkOutput($sformatf("K_OUT[%0d]", e.r), K_OUT, 32'd0);
`endif
                obsW[ROUND] = W_OUT;
            end
        end
        prevStall = OUT_VALID && !OUT_READY && !RESET;
        prevW     = W_OUT;
        prevR     = ROUND;
    end

    initial begin
        w32_t abc [16];
        w32_t zero [16];
        w32_t hello [16];
        int   doneAt;
        int   doneBefore;
        int   accept1;
        int   guard;
        bit   hit;

        abc   = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        zero  = '{default: 32'h0};
        hello = '{32'h48656c6c, 32'h6f20776f, 32'h726c6421, 32'h80000000,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000060};

        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_WORD   = '0;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_in_ready", 32'(IN_READY), 32'd0);
        checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("rst_W_OUT", W_OUT, 32'd0);
        checkOutput("rst_K_OUT", K_OUT, 32'd0);
        checkOutput("rst_ROUND", 32'(ROUND), 32'd0);
        checkOutput("rst_block_done", 32'(BLOCK_DONE), 32'd0);
        RESET = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", 32'(IN_READY), 32'd1);

        $display("[TB] block abc");
        applyStimulus(abc, 1'b0);
        waitDone(1'b0, doneAt);
        checkOutput("abc_done_cycle", 32'(doneAt - firstAccept), 32'd79);
        checkOutput("abc_W0", obsW[0], 32'h61626380);
        checkOutput("abc_W15", obsW[15], 32'h00000018);
        checkOutput("abc_W16", obsW[16], 32'h61626380);
        checkOutput("abc_W17", obsW[17], 32'h000f0000);

        $display("[TB] all-zero block");
        doneBefore = doneCount;
        applyStimulus(zero, 1'b0);
        waitDone(1'b0, doneAt);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("zero_done_once", 32'(doneCount - doneBefore), 32'd1);

        $display("[TB] hello world block");
        applyStimulus(hello, 1'b0);
        waitDone(1'b0, doneAt);

        $display("[TB] abc with random back-pressure");
        applyStimulus(abc, 1'b0);
        waitDone(1'b1, doneAt);
        checkOutput("bp_W17", obsW[17], 32'h000f0000);

        $display("[TB] reset mid-block");
        applyStimulus(abc, 1'b0);
        hit   = 1'b0;
        guard = 0;
        while (!hit && guard < 200) begin
            @(posedge CLK);
            #1;
            hit = OUT_VALID && (ROUND == 6'd30);
            guard++;
        end
        checkOutput("reach_round30", 32'(hit), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("midrst_ROUND", 32'(ROUND), 32'd0);
        checkOutput("midrst_in_ready", 32'(IN_READY), 32'd0);
        RESET = 1'b0;
        sb.delete();
        #1;
        checkOutput("midrst_in_ready_after", 32'(IN_READY), 32'd1);
        applyStimulus(abc, 1'b0);
        waitDone(1'b0, doneAt);
        checkOutput("postrst_W16", obsW[16], 32'h61626380);

        $display("[TB] IN_VALID held in RUN, back-to-back blocks");
        doneBefore = doneCount;
        applyStimulus(hello, 1'b1);
        accept1 = firstAccept;
        applyStimulus(abc, 1'b0);
        checkOutput("b2b_second_load_start", 32'(firstAccept - accept1), 32'd81);
        waitDone(1'b0, doneAt);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("b2b_done_count", 32'(doneCount - doneBefore), 32'd2);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
